divisor_multicanal: RTL

Multi-channel programmable clock divider and LED pattern generator. Each channel divides the system clock by a runtime-loadable period. Each channel drives one LED in one of four modes: toggle, single-cycle pulse, PWM or off. The block sits between the board clock and the front-panel LEDs and also serves as the time-base source (per-channel `Tick`) for display-multiplexing logic.

---
 rtl/divisor_multicanal.sv | 82 ++++++++
 1 files changed

// File: rtl/divisor_multicanal.sv
// Multi-channel programmable clock divider with per-channel LED pattern
// generator (toggle, pulse, PWM, off) and period tick outputs.
module divisor_multicanal #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 50000000,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Enable,
  input  logic                Cfg_we,
  input  logic [CH_W-1:0]     Cfg_ch,
  input  logic [1:0]          Cfg_mode,
  input  logic [CNT_W-1:0]    Cfg_period,
  input  logic [CNT_W-1:0]    Cfg_duty,
  output logic [CHANNELS-1:0] Led,
  output logic [CHANNELS-1:0] Tick
);

  localparam logic [1:0] M_TOG   = 2'b00;
  localparam logic [1:0] M_PULSE = 2'b01;
  localparam logic [1:0] M_PWM   = 2'b10;
  localparam logic [1:0] M_OFF   = 2'b11;

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_PERIOD / 2);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [1:0]       mode;
    logic             led;
    logic             tick;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] nxt;
    logic             term;
    logic             hit;

    // period 0 collapses onto period 1, so last never underflows
    always_comb begin
      last = (period == '0) ? '0 : period - CNT_W'(1);
      term = Enable[i] && (cnt == last);
      nxt  = term ? '0 : cnt + CNT_W'(1);
      hit  = Cfg_we && (Cfg_ch == CH_W'(i));
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        cnt    <= '0;
        period <= DEF_P;
        duty   <= DEF_D;
        mode   <= M_TOG;
        led    <= 1'b0;
        tick   <= 1'b0;
      end else if (hit) begin
        cnt    <= '0;
        period <= Cfg_period;
        duty   <= Cfg_duty;
        mode   <= Cfg_mode;
        led    <= 1'b0;
        tick   <= 1'b0;
      end else if (Enable[i]) begin
        cnt  <= nxt;
        tick <= term;
        unique case (mode)
          M_TOG:   led <= led ^ term;
          M_PULSE: led <= term;
          M_PWM:   led <= (nxt < duty);
          M_OFF:   led <= 1'b0;
        endcase
      end else begin
        tick <= 1'b0;
      end
    end

    assign Led[i]  = led;
    assign Tick[i] = tick;
  end

endmodule
